pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline hazard controller; produces stall/bubble strobes consumed by f/d/e/m/w pipeline registers.
//  Detects load/use, ret-in-flight, jXX mispredict and exception hazards from stage icodes/regs.
//  Sticky RUN/DRAIN/HALTED machine freezes the pipe after a faulting instruction retires.
//  Also gates condition-code writes (set_cc) for the execute stage.
// PARAMETERS
//  STAT_AOK  1  stat code: normal; STAT_HLT 2 halt; STAT_ADR 3 bad address; STAT_INS 4 bad instruction
//  CNT_W     32 width of perf counters (only with PIPE_CTRL_PERF_EN)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  D_icode    in   4   icode in decode stage
//  d_srcA     in   4   decode srcA (4'hF = none)
//  d_srcB     in   4   decode srcB (4'hF = none)
//  E_icode    in   4   icode in execute stage
//  E_destM    in   4   execute-stage memory destination (4'hF = none)
//  e_Cnd      in   1   branch condition computed in execute
//  M_icode    in   4   icode in memory stage
//  m_stat     in   4   status leaving memory stage
//  W_stat     in   4   status in writeback stage
//  F_stall    out  1   hold fetch PC register
//  D_stall    out  1   hold decode register
//  D_bubble   out  1   inject nop into decode register
//  E_bubble   out  1   inject nop (icode 1, destE/destM = F) into execute register
//  M_bubble   out  1   inject nop into memory register
//  W_stall    out  1   hold writeback register
//  set_cc     out  1   execute stage may update CC
//  cpu_halted out  1   pipeline frozen; only rst_n recovers
// BEHAVIOUR
//  icodes: MRMOVQ=5, OPQ=6, JXX=7, RET=9, POPQ=B. exc(s) = (s==HLT|ADR|INS).
//  lu  = (E_icode==5|B) && E_destM!=F && (E_destM==d_srcA || E_destM==d_srcB)
//  ret = RET in any of D_icode, E_icode, M_icode;  mp = (E_icode==7) && !e_Cnd
//  RUN: F_stall=lu|ret; D_stall=lu; D_bubble=mp|(!lu&ret); E_bubble=mp|lu;
//       M_bubble=exc(m_stat)|exc(W_stat); W_stall=exc(W_stat);
//       set_cc=(E_icode==6)&!exc(m_stat)&!exc(W_stat).
//  Outputs are combinational from inputs+state (zero-cycle latency); state updates on posedge clk.
//  FSM: RUN -> DRAIN when exc(m_stat) && !exc(W_stat); RUN/DRAIN -> HALTED when exc(W_stat).
//       DRAIN -> RUN if exc(m_stat) drops without W fault (stale fault squashed by mispredict).
//  DRAIN: as RUN but M_bubble=1, set_cc=0 forced.
//  HALTED: F_stall=D_stall=W_stall=1, M_bubble=1, D_bubble=E_bubble=0, set_cc=0, cpu_halted=1;
//          inputs ignored; absorbing state.
//  Simultaneous lu & ret: stall wins in D (D_stall=1, D_bubble=0), E_bubble=1, F_stall=1.
//  Simultaneous mp & ret (ret in D): D_bubble=1, E_bubble=1, F_stall=1.
//  Reset (rst_n low, any time incl. mid-stall): state=RUN asynchronously; while low
//    D_bubble=E_bubble=M_bubble=1, F_stall=D_stall=W_stall=0, set_cc=0, cpu_halted=0.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: adds outputs cnt_stall, cnt_bubble, cnt_mispred [CNT_W-1:0];
//    +1 per clk when F_stall, when E_bubble, when mp (RUN/DRAIN only); saturate at all-ones;
//    cleared to 0 by rst_n; frozen in HALTED.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  E_icode=5,E_destM=3,d_srcA=3 -> F_stall=1,D_stall=1,E_bubble=1,D_bubble=0; E_destM=F -> all 0.
//  D_icode=9 for 3 cycles (D,E,M) -> F_stall=1,D_bubble=1 each cycle; then all 0.
//  E_icode=7,e_Cnd=0 -> D_bubble=1,E_bubble=1,F_stall=0; e_Cnd=1 -> none.
//  m_stat=3 then W_stat=3 next clk -> DRAIN (M_bubble=1,set_cc=0) then cpu_halted=1,W_stall=1 held 10 clks.
//  rst_n pulsed low mid-HALTED, async (no clk) -> cpu_halted=0, E_bubble=1 immediately; RUN after release.
//  PERF_EN: 5 lu cycles + 2 mispredicts -> cnt_stall=5, cnt_bubble=7, cnt_mispred=2.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller producing stall/bubble strobes, set_cc gating and a sticky halt machine.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter logic [3:0] STAT_AOK = 4'd1,
    parameter logic [3:0] STAT_HLT = 4'd2,
    parameter logic [3:0] STAT_ADR = 4'd3,
    parameter logic [3:0] STAT_INS = 4'd4
`ifdef PIPE_CTRL_PERF_EN
   ,parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_destM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [3:0] m_stat,
    input  logic [3:0] W_stat,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_bubble,
    output logic       W_stall,
    output logic       set_cc,
    output logic       cpu_halted
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_bubble,
    output logic [CNT_W-1:0] cnt_mispred
`endif
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
    state_e state_q, state_d;
    logic lu, ret, mp, exc_m, exc_w;

    function automatic logic exc(input logic [3:0] s);
        return s != STAT_AOK && (s == STAT_HLT || s == STAT_ADR || s == STAT_INS);
    endfunction

    assign exc_m = exc(m_stat);
    assign exc_w = exc(W_stat);
    assign lu    = (E_icode == 4'h5 || E_icode == 4'hB) && E_destM != 4'hF &&
                   (E_destM == d_srcA || E_destM == d_srcB);
    assign ret   = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    assign mp    = E_icode == 4'h7 && !e_Cnd;

    // A fault reaching W always wins; a DRAIN whose M fault vanishes was a squashed wrong-path fault.
    always_comb begin
        state_d = state_q;
        if (state_q != HALTED && exc_w) state_d = HALTED;
        else if (state_q == RUN && exc_m) state_d = DRAIN;
        else if (state_q == DRAIN && !exc_m) state_d = RUN;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= RUN;
        else state_q <= state_d;

    always_comb begin
        F_stall    = lu | ret;
        D_stall    = lu;
        D_bubble   = mp | (!lu & ret);
        E_bubble   = mp | lu;
        M_bubble   = exc_m | exc_w | (state_q == DRAIN);
        W_stall    = exc_w;
        set_cc     = E_icode == 4'h6 && !exc_m && !exc_w && state_q == RUN;
        cpu_halted = 1'b0;
        if (!rst_n) begin
            F_stall  = 1'b0;
            D_stall  = 1'b0;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b0;
            set_cc   = 1'b0;
        end else if (state_q == HALTED) begin
            F_stall    = 1'b1;
            D_stall    = 1'b1;
            D_bubble   = 1'b0;
            E_bubble   = 1'b0;
            M_bubble   = 1'b1;
            W_stall    = 1'b1;
            set_cc     = 1'b0;
            cpu_halted = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] cnt_stall_q, cnt_bubble_q, cnt_mispred_q;
    logic [CNT_W-1:0] cnt_stall_d, cnt_bubble_d, cnt_mispred_d;
    logic live;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && !(&c)) ? c + CNT_W'(1) : c;
    endfunction

    assign live         = state_q != HALTED;
    assign cnt_stall_d   = inc(cnt_stall_q, live & F_stall);
    assign cnt_bubble_d  = inc(cnt_bubble_q, live & E_bubble);
    assign cnt_mispred_d = inc(cnt_mispred_q, live & mp);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_stall_q   <= '0;
            cnt_bubble_q  <= '0;
            cnt_mispred_q <= '0;
        end else begin
            cnt_stall_q   <= cnt_stall_d;
            cnt_bubble_q  <= cnt_bubble_d;
            cnt_mispred_q <= cnt_mispred_d;
        end

    assign cnt_stall   = cnt_stall_q;
    assign cnt_bubble  = cnt_bubble_q;
    assign cnt_mispred = cnt_mispred_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus hand-written sequences for pipe_ctrl.
module tb_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_destM, M_icode, m_stat, W_stat;
    logic       e_Cnd;
    logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, cpu_halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cnt_stall, cnt_bubble, cnt_mispred;
`endif
    int n_vec = 0;
    int n_err = 0;

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, cpu_halted}
    logic [7:0] outs;
    assign outs = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, cpu_halted};

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_destM(E_destM), .e_Cnd(e_Cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .cpu_halted(cpu_halted)
`ifdef PIPE_CTRL_PERF_EN
       ,.cnt_stall(cnt_stall), .cnt_bubble(cnt_bubble), .cnt_mispred(cnt_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [3:0] d_icode, srca, srcb, e_icode, e_destm;
        logic       cnd;
        logic [3:0] m_icode;
        logic [7:0] exp;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(input string nm, input logic [3:0] di, sa, sb, ei, ed,
                                input logic c, input logic [3:0] mi, input logic [7:0] exp);
        vec_t v;
        v.nm = nm; v.d_icode = di; v.srca = sa; v.srcb = sb; v.e_icode = ei;
        v.e_destm = ed; v.cnd = c; v.m_icode = mi; v.exp = exp;
        return v;
    endfunction

    task automatic idle();
        D_icode = 4'h0; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h0; E_destM = 4'hF;
        e_Cnd = 1'b0; M_icode = 4'h0; m_stat = 4'h1; W_stat = 4'h1;
    endtask

    task automatic set_lu();
        idle(); E_icode = 4'h5; E_destM = 4'h3; d_srcA = 4'h3;
    endtask

    task automatic chk(input string nm, input logic [7:0] exp);
        n_vec++;
        if (outs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, outs, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv.push_back(mk("idle",        4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 4'h0, 8'b0000_0000));
        tv.push_back(mk("lu_mrmov_a",  4'h0, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h0, 8'b1101_0000));
        tv.push_back(mk("lu_none",     4'h0, 4'hF, 4'hF, 4'h5, 4'hF, 1'b0, 4'h0, 8'b0000_0000));
        tv.push_back(mk("lu_popq_b",   4'h0, 4'hF, 4'h4, 4'hB, 4'h4, 1'b0, 4'h0, 8'b1101_0000));
        tv.push_back(mk("lu_nomatch",  4'h0, 4'h4, 4'h5, 4'h5, 4'h3, 1'b0, 4'h0, 8'b0000_0000));
        tv.push_back(mk("nop_dest",    4'h0, 4'h3, 4'hF, 4'h1, 4'h3, 1'b0, 4'h0, 8'b0000_0000));
        tv.push_back(mk("opq_setcc",   4'h0, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h0, 8'b0000_0010));
        tv.push_back(mk("ret_d",       4'h9, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 4'h0, 8'b1010_0000));
        tv.push_back(mk("ret_e",       4'h0, 4'hF, 4'hF, 4'h9, 4'hF, 1'b0, 4'h0, 8'b1010_0000));
        tv.push_back(mk("ret_m",       4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 4'h9, 8'b1010_0000));
        tv.push_back(mk("ret_done",    4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 4'h0, 8'b0000_0000));
        tv.push_back(mk("mispred",     4'h0, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h0, 8'b0011_0000));
        tv.push_back(mk("jxx_taken",   4'h0, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h0, 8'b0000_0000));
        tv.push_back(mk("lu_and_ret",  4'h9, 4'h2, 4'hF, 4'h5, 4'h2, 1'b0, 4'h0, 8'b1101_0000));
        tv.push_back(mk("mp_and_ret",  4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h0, 8'b1011_0000));

        idle();
        rst_n = 1'b0;
        #2 chk("reset_init", 8'b0011_1000);
`ifdef PIPE_CTRL_PERF_EN
        chk_cnt("cnt_stall_rst", cnt_stall, 0);
`endif
        #4 rst_n = 1'b1;
        #1 chk("run_after_init", 8'b0000_0000);
        tick();

        foreach (tv[i]) begin
            D_icode = tv[i].d_icode; d_srcA = tv[i].srca; d_srcB = tv[i].srcb;
            E_icode = tv[i].e_icode; E_destM = tv[i].e_destm; e_Cnd = tv[i].cnd;
            M_icode = tv[i].m_icode;
            #1 chk(tv[i].nm, tv[i].exp);
            tick();
        end

        // M fault -> DRAIN -> W fault -> HALTED, held across arbitrary inputs
        idle(); E_icode = 4'h6; m_stat = 4'h3;
        #1 chk("run_m_exc", 8'b0000_1000);
        tick();
        m_stat = 4'h1;
        #1 chk("drain_forced", 8'b0000_1000);
        m_stat = 4'h3; W_stat = 4'h3;
        #1 chk("drain_w_exc", 8'b0000_1100);
        tick();
        set_lu(); D_icode = 4'h9;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("halted_%0d", k), 8'b1100_1101);
            tick();
        end
        #2 rst_n = 1'b0;
        #1 chk("async_rst_halted", 8'b0011_1000);
        idle();
        rst_n = 1'b1;
        #1 chk("run_after_rst", 8'b0000_0000);

        // stale M fault squashed: DRAIN returns to RUN
        tick();
        m_stat = 4'h3;
        tick();
        m_stat = 4'h1; E_icode = 4'h6;
        #1 chk("drain_stale", 8'b0000_1000);
        tick();
        chk("squash_to_run", 8'b0000_0010);

        // reset asserted in the middle of a load/use stall
        set_lu();
        #1 chk("lu_pre_rst", 8'b1101_0000);
        rst_n = 1'b0;
        #1 chk("rst_mid_stall", 8'b0011_1000);
        rst_n = 1'b1;
        #1 chk("lu_post_rst", 8'b1101_0000);

        // W fault straight from RUN
        idle();
        tick();
        W_stat = 4'h4;
        #1 chk("run_w_exc", 8'b0000_1100);
        tick();
        W_stat = 4'h1;
        chk("halted_w_ins", 8'b1100_1101);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1 chk("run_after_w_rst", 8'b0000_0000);

`ifdef PIPE_CTRL_PERF_EN
        tick();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        set_lu();
        repeat (5) @(posedge clk);
        #1 idle(); E_icode = 4'h7;
        repeat (2) @(posedge clk);
        #1 idle();
        tick();
        chk_cnt("cnt_stall", cnt_stall, 5);
        chk_cnt("cnt_bubble", cnt_bubble, 7);
        chk_cnt("cnt_mispred", cnt_mispred, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
